mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Multi-cycle 16x16 shift-add multiplier sequencer built around one shared 16-bit ripple-carry adder. An FSM reuses the adder for operand absolute value, 16 partial-product accumulations and 32-bit result negation. Sits beside the ALU datapath as the MUL/MULS execution unit, with a start/ready request handshake and a valid/ready result handshake.

Parameters:
WIDTH, 16, operand width (fixed at 16; product is 2*WIDTH)
CNT_W, 4, iteration counter width (log2 WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; accepted when start && ready at a rising edge
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
a  input  16  multiplicand; sampled at accept
b  input  16  multiplier; sampled at accept
ready  output  1  high only in IDLE
result  output  32  product {P_hi, Q}; valid only while result_valid=1
result_valid  output  1  product available; held until result_ready
result_ready  input  1  consumer accepts the result when result_valid && result_ready

Behaviour:
- Reset (reset=0, async): state IDLE, ready=1, result_valid=0, result=0, counter=0, internal registers M, P_hi, Q, carry, sign=0. Reset mid-operation aborts; no result is produced.
- States: IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, DONE.
- IDLE: on accept, M<=a, Q<=b, P_hi<=0, cnt<=0, sign<=signed_mode & (a[15]^b[15]), smode<=signed_mode. Next state ABS_A if signed_mode, else ITER.
- ABS_A: adder computes ~M+1; M<=result only if M[15]=1, else unchanged. Next ABS_B.
- ABS_B: same on Q. Next ITER. Both cycles are always spent in signed mode, so latency is fixed.
- ITER: adder computes {c,s}=P_hi+(Q[0]?M:0) with cin=0; {P_hi,Q}<={c,s,Q}>>1 (c enters P_hi[15]). cnt<=cnt+1. After the 16th ITER (cnt==15): NEG_LO if smode, else DONE.
- NEG_LO: adder computes ~Q+1; carry<=cout. Q updates only if sign=1. Next NEG_HI.
- NEG_HI: adder computes ~P_hi+carry (cin=carry). P_hi updates only if sign=1. Next DONE.
- DONE: result_valid=1, result={P_hi,Q}, stable. On result_ready: result_valid<=0, next IDLE. A new start is accepted no earlier than the cycle after return to IDLE.
- Latency, accept edge to result_valid high: unsigned 16 cycles; signed 20 cycles. Throughput: one op per latency+2 cycles minimum.
- start while ready=0 is ignored, with no queueing. a, b and signed_mode are ignored outside the accept edge.
- Arithmetic: exactly one 16-bit adder instance, whose operands are muxed by state. Unsigned product range 0..0xFFFE0001. The signed case -32768 * -32768 is correct because abs(0x8000) is treated as unsigned 32768, giving 0x40000000.
- result_ready while result_valid=0 has no effect.

Test Plan:
- Unsigned a=3, b=5, start one cycle -> result_valid rises exactly 16 cycles after accept, result=0x0000000F; result_ready=1 -> ready=1 the next cycle.
- Unsigned a=0xFFFF, b=0xFFFF -> result=0xFFFE0001. Unsigned a=0, b=0x1234 -> result=0x00000000.
- Signed a=0xFFFD (-3), b=5 -> result_valid 20 cycles after accept, result=0xFFFFFFF1. Signed a=-7, b=-6 -> result=0x0000002A.
- Signed a=0x8000, b=0x8000 -> result=0x40000000. Signed a=0x8000, b=1 -> result=0xFFFF8000.
- Backpressure: hold result_ready=0 for 5 cycles and pulse start with new operands meanwhile -> result stays constant, ready=0, start ignored. After result_ready, a new start is accepted and produces the correct product.
- Assert reset=0 asynchronously (mid-clock) during ITER cnt=7 -> outputs clear immediately: ready=1, result_valid=0, result=0. After release, a=2, b=2 unsigned -> result=4 at 16 cycles.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mult_seq_ctrl : 16x16 shift-add MUL/MULS sequencer sharing one 16-bit adder
// Revision: 1.0
// ============================================================================
module mult_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid,
   input  logic                 result_ready
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ABS_A  = 3'd1,
      S_ABS_B  = 3'd2,
      S_ITER   = 3'd3,
      S_NEG_LO = 3'd4,
      S_NEG_HI = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   state_t             r_state, w_next;
   logic [WIDTH-1:0]   r_m, r_phi, r_q;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry, r_sign, r_smode;
   logic [WIDTH-1:0]   w_add_a, w_add_b;
   logic               w_cin;
   logic [WIDTH:0]     w_sum;
   logic               w_accept;

   assign w_accept     = start && (r_state == S_IDLE);
   assign ready        = (r_state == S_IDLE);
   assign result_valid = (r_state == S_DONE);
   assign result       = (r_state == S_DONE) ? {r_phi, r_q} : '0;

   // The single shared adder; only its operands change with the state.
   assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      w_cin   = 1'b0;
      w_next  = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = signed_mode ? S_ABS_A : S_ITER;
         end
         S_ABS_A: begin
            w_add_a = ~r_m;
            w_cin   = 1'b1;
            w_next  = S_ABS_B;
         end
         S_ABS_B: begin
            w_add_a = ~r_q;
            w_cin   = 1'b1;
            w_next  = S_ITER;
         end
         S_ITER: begin
            w_add_a = r_phi;
            w_add_b = r_q[0] ? r_m : '0;
            if (r_cnt == c_last) w_next = r_smode ? S_NEG_LO : S_DONE;
         end
         S_NEG_LO: begin
            w_add_a = ~r_q;
            w_cin   = 1'b1;
            w_next  = S_NEG_HI;
         end
         S_NEG_HI: begin
            w_add_a = ~r_phi;
            w_cin   = r_carry;
            w_next  = S_DONE;
         end
         S_DONE: begin
            if (result_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_phi   <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sign  <= 1'b0;
         r_smode <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_m     <= a;
                  r_q     <= b;
                  r_phi   <= '0;
                  r_cnt   <= '0;
                  r_sign  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_smode <= signed_mode;
               end
            end
            S_ABS_A: if (r_m[WIDTH-1]) r_m <= w_sum[WIDTH-1:0];
            S_ABS_B: if (r_q[WIDTH-1]) r_q <= w_sum[WIDTH-1:0];
            S_ITER: begin
               // Adder carry becomes the new top bit as the pair shifts right.
               r_phi <= w_sum[WIDTH:1];
               r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
               r_cnt <= r_cnt + 1'b1;
            end
            S_NEG_LO: begin
               r_carry <= w_sum[WIDTH];
               if (r_sign) r_q <= w_sum[WIDTH-1:0];
            end
            S_NEG_HI: if (r_sign) r_phi <= w_sum[WIDTH-1:0];
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mult_seq_ctrl : directed + random checks of mult_seq_ctrl against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        ready;
   logic [31:0] result;
   logic        result_valid;
   logic        result_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   mult_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .signed_mode  (signed_mode),
      .a            (a),
      .b            (b),
      .ready        (ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic sm);
      longint px, py;
      px = sm ? longint'($signed(x)) : longint'(x);
      py = sm ? longint'($signed(y)) : longint'(y);
      return 32'(px * py);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; hold>0 delays result_ready and pokes start meanwhile.
   task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic sm,
                        input int hold, input string tag);
      int n;
      int lat;
      logic [31:0] held;
      n = 0;
      @(negedge clk);
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_before"}, 64'(ready), 64'd1);
      start = 1'b1; a = xa; b = xb; signed_mode = sm;
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), sm ? 64'd20 : 64'd16);
      chk({tag, "_result"}, 64'(result), 64'(ref_mul(xa, xb, sm)));
      held = result;
      for (int i = 0; i < hold; i++) begin
         start = 1'b1; a = 16'($urandom); b = 16'($urandom);
         @(negedge clk);
         start = 1'b0;
         chk({tag, "_bp_ready"}, 64'(ready), 64'd0);
         chk({tag, "_bp_valid"}, 64'(result_valid), 64'd1);
         chk({tag, "_bp_stable"}, 64'(result), 64'(held));
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, "_ready_after"}, 64'(ready), 64'd1);
      chk({tag, "_valid_after"}, 64'(result_valid), 64'd0);
      if (hold > 0) begin
         @(negedge clk);
         chk({tag, "_no_queue"}, 64'(ready), 64'd1);
      end
   endtask

   initial begin
      #3;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_valid", 64'(result_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op(16'd3,      16'd5,      1'b0, 0, "u_3x5");
      do_op(16'hFFFF,   16'hFFFF,   1'b0, 0, "u_max");
      do_op(16'd0,      16'h1234,   1'b0, 0, "u_zero");
      do_op(16'hFFFD,   16'd5,      1'b1, 0, "s_m3x5");
      do_op(16'hFFF9,   16'hFFFA,   1'b1, 0, "s_m7xm6");
      do_op(16'h8000,   16'h8000,   1'b1, 0, "s_minxmin");
      do_op(16'h8000,   16'd1,      1'b1, 0, "s_minx1");
      do_op(16'd0,      16'hFFFB,   1'b1, 0, "s_0xm5");
      do_op(16'h1234,   16'h5678,   1'b0, 5, "bp_u");
      do_op(16'hABCD,   16'h0077,   1'b1, 0, "after_bp");

      for (int i = 0; i < 16; i++)
         do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");

      // Abort mid-iteration with an asynchronous reset.
      @(negedge clk);
      start = 1'b1; a = 16'h00FF; b = 16'h0F0F; signed_mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_valid", 64'(result_valid), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      do_op(16'd2, 16'd2, 1'b0, 0, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
